cam_agent: RTL
==============

# cam_agent

Requester-side controller for the 16×8 `Content_Addressable_Memory` block. It accepts lookup and insert requests over a valid/ready handshake and drives the CAM's `wen`/`ren`/`din`/`addr` pins. It allocates CAM slots in ascending order and returns the matching address, hit, full and error status over a valid/ready response channel. It sits between a key-producing client and the CAM, so clients never sequence CAM pins themselves.

## Interface
- `DEPTH`, 16, number of CAM entries
- `KEY_W`, 8, key width in bits
- `ADDR_W`, 4, CAM address width
- `clk` input 1 — single clock; everything changes on the rising edge
- `rst` input 1 — synchronous, active-high reset
- `req_valid` input 1 — request present
- `req_ready` output 1 — agent can accept a request
- `req_op` input 1 — 0 = lookup, 1 = insert
- `req_key` input KEY_W — key to search or store
- `resp_valid` output 1 — response present
- `resp_ready` input 1 — client accepts the response
- `resp_addr` output ADDR_W — matching or allocated address
- `resp_hit` output 1 — key was already present
- `resp_full` output 1 — insert refused because no free slot
- `resp_err` output 1 — key equals the reserved sentinel (all ones)
- `cam_wen`, `cam_ren` output 1 — CAM write and search enables
- `cam_din` output KEY_W — CAM data or search key
- `cam_addr` output ADDR_W — CAM write address
- `cam_dout` input ADDR_W — CAM matched address, registered by the CAM
- `cam_hit` input 1 — CAM match flag, registered by the CAM
- `count` output ADDR_W+1 — number of allocated entries (0..DEPTH)

## Operation
- CAM contract:
  - A write happens on the edge where `wen`=1 and `ren`=0.
  - A search happens on the edge where `ren`=1. `cam_dout`/`cam_hit` update on that edge and are sampled the following cycle.
  - On a multi-match, the CAM returns the highest matching address.
- The sentinel key is all ones (0xFF). Every entry holds either the sentinel or a client key, so stale data never aliases a real key.
- States:
  - INIT: writes the sentinel to address `init_ptr`, stepping 0..DEPTH-1, one write per cycle. After the write to DEPTH-1 it goes to IDLE.
  - IDLE: `req_ready`=1. On `req_valid`, it latches op and key.
    - If the key is the sentinel, it goes to RESP with `resp_err`=1 and no CAM access.
    - Otherwise it goes to SEARCH.
  - SEARCH: drives `cam_ren`=1 and `cam_din`=key, then goes to CHECK.
  - CHECK: computes `valid_hit = cam_hit && (cam_dout < count)`.
    - Lookup: goes to RESP with `resp_hit`=`valid_hit` and `resp_addr`=`cam_dout` on a hit, else 0.
    - Insert with `valid_hit`: goes to RESP with `resp_hit`=1 and `resp_addr`=`cam_dout`. No write is done.
    - Insert with no hit and `count`<DEPTH: goes to WRITE.
    - Insert with no hit and `count`==DEPTH: goes to RESP with `resp_full`=1 and `resp_addr`=0.
  - WRITE: drives `cam_wen`=1, `cam_ren`=0, `cam_addr`=`count[ADDR_W-1:0]`, `cam_din`=key. `count` increments. Goes to RESP with `resp_addr` equal to the old `count` and `resp_hit`=0.
  - RESP: `resp_valid`=1 with all response fields stable. When `resp_ready`=1 it goes to IDLE.
- Entries are never freed. Only `rst` empties the table.
- Exactly one of these holds per response: err, full, hit, or none (lookup miss or fresh insert).

## Timing
- Reset values:
  - `req_ready`, `resp_valid`, `resp_hit`, `resp_full`, `resp_err` = 0.
  - `resp_addr`, `count`, `init_ptr` = 0.
  - `cam_wen`=0, `cam_ren`=0, `cam_din`=0, `cam_addr`=0.
  - The state after reset is INIT.
- INIT lasts exactly DEPTH cycles after `rst` is released. `req_ready` first rises in cycle DEPTH+1.
- Latency counts edges from the accept edge (`req_valid && req_ready`) to `resp_valid` being high:
  - Sentinel error: 1 edge.
  - Lookup, insert-hit, or full: 3 edges (IDLE→SEARCH→CHECK→RESP).
  - New insert: 4 edges.
- `req_ready` is high only in IDLE, so there is one outstanding request at a time. `resp_valid` stays high until the `resp_ready` edge.
- If `resp_ready` is already high when RESP is entered, the response completes in one cycle. The next request can be accepted on the edge after that.
- The CAM outputs are Moore outputs, registered per state. `cam_wen` and `cam_ren` are never both 1.
- `rst` mid-operation has priority over everything. It aborts any state, drops `resp_valid`, clears `count` and restarts INIT.

## Structure
- Package `cam_agent_pkg` holds:
  - State encoding: INIT, IDLE, SEARCH, CHECK, WRITE, RESP.
  - `OP_LOOKUP`=0 and `OP_INSERT`=1.
  - `SENTINEL` = {KEY_W{1'b1}}.
- This is a single module with no sub-module. The bench instantiates `cam_agent` together with `Content_Addressable_Memory`.

## Test plan
- Reset, then idle: `req_ready` stays 0 for 16 cycles with `cam_wen`=1 and `cam_addr` stepping 0..15 with `cam_din`=0xFF. `req_ready` rises in cycle 17.
- Insert 50, insert 2, insert 2: responses are addr 0 hit 0, then addr 1 hit 0, then addr 1 hit 1. Afterwards `count`=2.
- Lookup 50 → addr 0 hit 1. Lookup 20 → hit 0 addr 0. Each `resp_valid` appears 3 edges after accept.
- Insert keys 0..15, then insert 100 → sixteen responses with addr 0..15. The last request gets `resp_full`=1 and `count` stays 16.
- Request key 0xFF with either op → `resp_err`=1 one edge after accept, with no `cam_ren` or `cam_wen` pulse.
- Hold `resp_ready`=0 for 5 cycles: `resp_valid` and its fields stay stable. Then assert `rst` during SEARCH: next cycle `resp_valid`=0, `count`=0, and INIT restarts at addr 0.

Source files
------------

// File: rtl/cam_agent_pkg.sv
// Shared types and constants for the CAM requester agent.
package cam_agent_pkg;

  typedef enum logic [2:0] {
    StInit,
    StIdle,
    StSearch,
    StCheck,
    StWrite,
    StResp
  } state_e;

  localparam logic OP_LOOKUP = 1'b0;
  localparam logic OP_INSERT = 1'b1;

  localparam int unsigned   SENT_W   = 8;
  localparam logic [SENT_W-1:0] SENTINEL = {SENT_W{1'b1}};

endpackage

// File: rtl/cam_agent.sv
// Requester-side controller for a 16x8 CAM: sentinel-fills the table, then serves
// lookup/insert requests with ascending slot allocation over valid/ready channels.
module cam_agent
  import cam_agent_pkg::*;
#(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned KEY_W  = 8,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_op,
  input  logic [KEY_W-1:0]  req_key,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [ADDR_W-1:0] resp_addr,
  output logic              resp_hit,
  output logic              resp_full,
  output logic              resp_err,
  output logic              cam_wen,
  output logic              cam_ren,
  output logic [KEY_W-1:0]  cam_din,
  output logic [ADDR_W-1:0] cam_addr,
  input  logic [ADDR_W-1:0] cam_dout,
  input  logic              cam_hit,
  output logic [ADDR_W:0]   count
);

  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   FullCnt  = (ADDR_W + 1)'(DEPTH);
  localparam logic [KEY_W-1:0]  SentKey  = KEY_W'(SENTINEL);

  state_e              r_state, w_state_d;
  logic [ADDR_W-1:0]   r_init_ptr, w_init_ptr_d;
  logic                r_op, w_op_d;
  logic [KEY_W-1:0]    r_key, w_key_d;
  logic [ADDR_W:0]     r_count, w_count_d;
  logic [ADDR_W-1:0]   r_resp_addr, w_resp_addr_d;
  logic                r_resp_hit, w_resp_hit_d;
  logic                r_resp_full, w_resp_full_d;
  logic                r_resp_err, w_resp_err_d;

  logic                r_req_ready, w_req_ready_d;
  logic                r_resp_valid, w_resp_valid_d;
  logic                r_cam_wen, w_cam_wen_d;
  logic                r_cam_ren, w_cam_ren_d;
  logic [KEY_W-1:0]    r_cam_din, w_cam_din_d;
  logic [ADDR_W-1:0]   r_cam_addr, w_cam_addr_d;

  logic                w_valid_hit;

  // Slots at or above count still hold the sentinel, so matches there are stale.
  assign w_valid_hit = cam_hit && ({1'b0, cam_dout} < r_count);

  always_comb begin
    w_state_d     = r_state;
    w_init_ptr_d  = r_init_ptr;
    w_op_d        = r_op;
    w_key_d       = r_key;
    w_count_d     = r_count;
    w_resp_addr_d = r_resp_addr;
    w_resp_hit_d  = r_resp_hit;
    w_resp_full_d = r_resp_full;
    w_resp_err_d  = r_resp_err;

    case (r_state)
      StInit: begin
        // The pointer only advances once its write has actually been driven.
        if (r_cam_wen) begin
          w_init_ptr_d = r_init_ptr + 1'b1;
          if (r_init_ptr == LastAddr) w_state_d = StIdle;
        end
      end
      StIdle: begin
        if (req_valid) begin
          w_op_d  = req_op;
          w_key_d = req_key;
          if (req_key == SentKey) begin
            w_state_d     = StResp;
            w_resp_err_d  = 1'b1;
            w_resp_hit_d  = 1'b0;
            w_resp_full_d = 1'b0;
            w_resp_addr_d = '0;
          end else begin
            w_state_d = StSearch;
          end
        end
      end
      StSearch: w_state_d = StCheck;
      StCheck: begin
        w_resp_err_d  = 1'b0;
        w_resp_full_d = 1'b0;
        w_resp_hit_d  = w_valid_hit;
        w_resp_addr_d = w_valid_hit ? cam_dout : '0;
        if (r_op == OP_LOOKUP || w_valid_hit) begin
          w_state_d = StResp;
        end else if (r_count < FullCnt) begin
          w_state_d = StWrite;
        end else begin
          w_state_d     = StResp;
          w_resp_full_d = 1'b1;
        end
      end
      StWrite: begin
        w_count_d     = r_count + 1'b1;
        w_resp_addr_d = r_count[ADDR_W-1:0];
        w_resp_hit_d  = 1'b0;
        w_state_d     = StResp;
      end
      StResp: begin
        if (resp_ready) w_state_d = StIdle;
      end
      default: w_state_d = StInit;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state register.
  always_comb begin
    w_req_ready_d  = (w_state_d == StIdle);
    w_resp_valid_d = (w_state_d == StResp);
    w_cam_wen_d    = 1'b0;
    w_cam_ren_d    = 1'b0;
    w_cam_din_d    = '0;
    w_cam_addr_d   = '0;
    case (w_state_d)
      StInit: begin
        w_cam_wen_d  = 1'b1;
        w_cam_din_d  = SentKey;
        w_cam_addr_d = w_init_ptr_d;
      end
      StSearch: begin
        w_cam_ren_d = 1'b1;
        w_cam_din_d = w_key_d;
      end
      StWrite: begin
        w_cam_wen_d  = 1'b1;
        w_cam_din_d  = w_key_d;
        w_cam_addr_d = w_count_d[ADDR_W-1:0];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= StInit;
      r_init_ptr   <= '0;
      r_op         <= 1'b0;
      r_key        <= '0;
      r_count      <= '0;
      r_resp_addr  <= '0;
      r_resp_hit   <= 1'b0;
      r_resp_full  <= 1'b0;
      r_resp_err   <= 1'b0;
      r_req_ready  <= 1'b0;
      r_resp_valid <= 1'b0;
      r_cam_wen    <= 1'b0;
      r_cam_ren    <= 1'b0;
      r_cam_din    <= '0;
      r_cam_addr   <= '0;
    end else begin
      r_state      <= w_state_d;
      r_init_ptr   <= w_init_ptr_d;
      r_op         <= w_op_d;
      r_key        <= w_key_d;
      r_count      <= w_count_d;
      r_resp_addr  <= w_resp_addr_d;
      r_resp_hit   <= w_resp_hit_d;
      r_resp_full  <= w_resp_full_d;
      r_resp_err   <= w_resp_err_d;
      r_req_ready  <= w_req_ready_d;
      r_resp_valid <= w_resp_valid_d;
      r_cam_wen    <= w_cam_wen_d;
      r_cam_ren    <= w_cam_ren_d;
      r_cam_din    <= w_cam_din_d;
      r_cam_addr   <= w_cam_addr_d;
    end
  end

  assign req_ready  = r_req_ready;
  assign resp_valid = r_resp_valid;
  assign resp_addr  = r_resp_addr;
  assign resp_hit   = r_resp_hit;
  assign resp_full  = r_resp_full;
  assign resp_err   = r_resp_err;
  assign cam_wen    = r_cam_wen;
  assign cam_ren    = r_cam_ren;
  assign cam_din    = r_cam_din;
  assign cam_addr   = r_cam_addr;
  assign count      = r_count;

endmodule
